fp8_div_seq: RTL



---
 rtl/fp8_div_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fp8_div_seq.sv
// Sequential FP8 divider {sign, exp[2:0] bias EXP_BIAS, frac[3:0]}: restoring
// one-bit-per-cycle mantissa division. Define FP8_DIV_ROUND_EN for round-to-nearest-even.
module fp8_div_seq #(
    parameter int EXP_BIAS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] result,
    output logic [3:0] flags
);

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    localparam logic signed [5:0] BIAS_S = 6'(EXP_BIAS);

    state_t      state_q;
    logic        sign_q, a_zero_q, b_zero_q;
    logic [2:0]  ea_q, eb_q, cnt_q;
    logic [4:0]  mb_q;
    logic [5:0]  rem_q;
    logic [6:0]  quo_q;
    logic [7:0]  result_q;
    logic [3:0]  flags_q;
    logic        out_valid_q;

    logic        div_ge_d;
    logic [5:0]  div_diff_d;
    logic signed [5:0] exp_d;
    logic [3:0]  man_d, man_rnd_d;
    logic        guard_d, sticky_d, round_up_d, carry_d;
    logic [7:0]  result_d;
    logic [3:0]  flags_d;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

    // Partial remainder is always < 2*mb, so one compare/subtract yields one quotient bit.
    always_comb begin
        div_ge_d   = (rem_q >= {1'b0, mb_q});
        div_diff_d = div_ge_d ? (rem_q - {1'b0, mb_q}) : rem_q;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        exp_d      = $signed({3'b000, ea_q}) - $signed({3'b000, eb_q}) + BIAS_S;
        man_d      = quo_q[5:2];
        guard_d    = quo_q[1];
        sticky_d   = quo_q[0] | (rem_q != 6'd0);
        if (!quo_q[6]) begin
            man_d    = quo_q[4:1];
            guard_d  = quo_q[0];
            sticky_d = (rem_q != 6'd0);
            exp_d    = exp_d - 6'sd1;
        end
`ifdef FP8_DIV_ROUND_EN
        round_up_d = guard_d & (sticky_d | man_d[0]);
`else
        round_up_d = 1'b0;
`endif
        {carry_d, man_rnd_d} = {1'b0, man_d} + {4'b0000, round_up_d};
        if (carry_d) exp_d = exp_d + 6'sd1;

        result_d = {sign_q, exp_d[2:0], man_rnd_d};
        flags_d  = 4'b0000;
        if (a_zero_q && b_zero_q) begin
            result_d = 8'h7F;
            flags_d  = 4'b1000;
        end else if (b_zero_q) begin
            result_d = {sign_q, 7'h70};
            flags_d  = 4'b0100;
        end else if (a_zero_q) begin
            result_d = 8'h00;
        end else if (exp_d > 6'sd7) begin
            result_d = {sign_q, 7'h70};
            flags_d  = 4'b0010;
        end else if (exp_d[5] || (exp_d == 6'sd0 && man_rnd_d == 4'd0)) begin
            // A zero exponent with zero fraction would alias the zero encoding.
            result_d = 8'h00;
            flags_d  = 4'b0001;
        end
    end

`ifndef FP8_DIV_ROUND_EN
    logic unused_round;
    assign unused_round = ^{guard_d, sticky_d};
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: every register, not only the FSM state, is cleared by reset so an aborted op leaves no residue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            a_zero_q    <= 1'b0;
            b_zero_q    <= 1'b0;
            ea_q        <= 3'd0;
            eb_q        <= 3'd0;
            cnt_q       <= 3'd0;
            mb_q        <= 5'd0;
            rem_q       <= 6'd0;
            quo_q       <= 7'd0;
            result_q    <= 8'h00;
            flags_q     <= 4'h0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    sign_q   <= a[7] ^ b[7];
                    a_zero_q <= (a[6:0] == 7'd0);
                    b_zero_q <= (b[6:0] == 7'd0);
                    ea_q     <= a[6:4];
                    eb_q     <= b[6:4];
                    mb_q     <= {1'b1, b[3:0]};
                    rem_q    <= {2'b01, a[3:0]};
                    quo_q    <= 7'd0;
                    cnt_q    <= 3'd6;
                    state_q  <= DIV;
                end
                DIV: begin
                    quo_q <= {quo_q[5:0], div_ge_d};
                    if (cnt_q == 3'd0) begin
                        rem_q   <= div_diff_d;
                        state_q <= NORM;
                    end else begin
                        rem_q <= {div_diff_d[4:0], 1'b0};
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                NORM: begin
                    result_q    <= result_d;
                    flags_q     <= flags_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
